// File: rtl/conv_layer_sequencer_pkg.sv
// Shared encodings for the convolution layer sequencer: FSM states,
// input-interface command/ack codes and a ceil-log2 width helper.
package conv_kernel_param;

    typedef enum logic [2:0] {
        STATE_IDLE    = 3'd0,
        STATE_PRELOAD = 3'd1,
        STATE_SHIFT   = 3'd2,
        STATE_LOAD    = 3'd3,
        STATE_DRAIN   = 3'd4
    } state_e;

    localparam logic [1:0] CMD_IDLE  = 2'd0;
    localparam logic [1:0] CMD_LOAD  = 2'd1;
    localparam logic [1:0] CMD_SHIFT = 2'd2;

    localparam logic [1:0] ACK_IDLE      = 2'd0;
    localparam logic [1:0] ACK_LOAD_FIN  = 2'd1;
    localparam logic [1:0] ACK_SHIFT_FIN = 2'd2;

    // Counter width for a range of 'value' entries, never narrower than one bit
    function automatic int logb2(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/conv_layer_sequencer_valid.sv
// Fixed-latency result pipeline: carries {valid, payload} through DEPTH
// register stages, zeroes payload on empty slots, flushes synchronously.
module conv_valid_pipe #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty
);

    logic [DEPTH-1:0] r_vld;
    logic [WIDTH-1:0] r_data [DEPTH];

    // Stage shift with flush; idle slots carry zero tags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
            end
        end else if (i_flush) begin
            r_vld <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            r_vld[0]  <= i_valid;
            r_data[0] <= i_valid ? i_data : '0;
            for (int i = 1; i < DEPTH; i++) begin
                r_vld[i]  <= r_vld[i-1];
                r_data[i] <= r_data[i-1];
            end
        end
    end

    assign o_valid = r_vld[DEPTH-1];
    assign o_data  = r_data[DEPTH-1];
    assign o_empty = ~|r_vld;

endmodule

// File: rtl/conv_layer_sequencer.sv
// Multi-channel convolution layer sequencer: drives LOAD/SHIFT commands to the
// input interface and emits a tagged result stream to the accumulator bank.
module conv_layer_sequencer
    import conv_kernel_param::*;
#(
    parameter int KERNEL_SIZE   = 3,
    parameter int ARRAY_SIZE    = 6,
    parameter int TOTAL_WEIGHT  = 4,
    parameter int IN_CHANNELS   = 2,
    parameter int VALID_LATENCY = 3,
    localparam int CH_W  = logb2(IN_CHANNELS),
    localparam int W_W   = logb2(TOTAL_WEIGHT),
    localparam int ROW_W = logb2(ARRAY_SIZE)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             cfg_stride,
    input  logic [1:0]       input_interface_ack,
    input  logic             out_ready,
    output logic [1:0]       input_interface_cmd,
    output logic [CH_W-1:0]  input_interface_chan,
    output logic             valid,
    output logic [W_W-1:0]   feature_idx,
    output logic [ROW_W-1:0] feature_row,
    output logic [CH_W-1:0]  feature_chan,
    output logic             acc_first,
    output logic             acc_last,
    output logic             image_calc_fin,
    output logic             busy
);

    localparam int KL_W  = logb2(KERNEL_SIZE);
    localparam int PAY_W = 3 + CH_W + ROW_W + W_W;

    localparam logic [CH_W-1:0]  LAST_CHAN   = CH_W'(IN_CHANNELS - 1);
    localparam logic [W_W-1:0]   LAST_WEIGHT = W_W'(TOTAL_WEIGHT - 1);
    localparam logic [ROW_W-1:0] LAST_ROW_S1 = ROW_W'(ARRAY_SIZE - 1);
    localparam logic [ROW_W-1:0] LAST_ROW_S2 = ROW_W'((ARRAY_SIZE - 1) >> 1);
    localparam logic [KL_W-1:0]  LOAD_PRE    = KL_W'(KERNEL_SIZE - 1);

    state_e           r_state;
    logic [1:0]       r_cmd;
    logic [CH_W-1:0]  r_chan;
    logic [W_W-1:0]   r_weight;
    logic [ROW_W-1:0] r_row;
    logic [KL_W-1:0]  r_load_cnt;
    logic             r_stride;
    logic             r_pend;
    logic             r_en_d;

    logic             w_last_chan;
    logic             w_last_weight;
    logic             w_last_row;
    logic [KL_W-1:0]  w_load_lim;
    logic             w_ack_load;
    logic             w_ack_shift;
    logic [1:0]       w_shift_cmd;
    logic             w_cap;
    logic [PAY_W-1:0] w_pay_in;
    logic [PAY_W-1:0] w_pay_out;
    logic             w_pipe_valid;
    logic             w_pipe_empty;

    assign w_last_chan   = (r_chan == LAST_CHAN);
    assign w_last_weight = (r_weight == LAST_WEIGHT);
    assign w_last_row    = (r_row == (r_stride ? LAST_ROW_S2 : LAST_ROW_S1));
    assign w_ack_load    = (input_interface_ack == ACK_LOAD_FIN);
    assign w_ack_shift   = (input_interface_ack == ACK_SHIFT_FIN);
    // A SHIFT that cannot go out now is parked in r_pend instead
    assign w_shift_cmd   = out_ready ? CMD_SHIFT : CMD_IDLE;
    assign w_load_lim    = (r_state == STATE_PRELOAD) ? LOAD_PRE
                         : (r_stride ? KL_W'(1) : {KL_W{1'b0}});
    assign w_cap         = (r_state == STATE_SHIFT) && !r_pend && w_ack_shift;
    assign w_pay_in      = {w_last_weight & w_last_chan & w_last_row,
                            r_chan == {CH_W{1'b0}}, w_last_chan,
                            r_chan, r_row, r_weight};

    // Sequencer FSM: one outstanding command, counters advance only on matching acks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= STATE_IDLE;
            r_cmd      <= CMD_IDLE;
            r_chan     <= '0;
            r_weight   <= '0;
            r_row      <= '0;
            r_load_cnt <= '0;
            r_stride   <= 1'b0;
            r_pend     <= 1'b0;
            r_en_d     <= 1'b0;
        end else if (!enable) begin
            r_state    <= STATE_IDLE;
            r_cmd      <= CMD_IDLE;
            r_chan     <= '0;
            r_weight   <= '0;
            r_row      <= '0;
            r_load_cnt <= '0;
            r_pend     <= 1'b0;
            r_en_d     <= 1'b0;
        end else begin
            r_en_d <= 1'b1;
            r_cmd  <= CMD_IDLE;
            case (r_state)
                STATE_IDLE: begin
                    // Only a fresh rising enable starts a frame
                    if (!r_en_d) begin
                        r_stride   <= cfg_stride;
                        r_chan     <= '0;
                        r_weight   <= '0;
                        r_row      <= '0;
                        r_load_cnt <= '0;
                        r_state    <= STATE_PRELOAD;
                        r_cmd      <= CMD_LOAD;
                    end
                end
                STATE_PRELOAD, STATE_LOAD: begin
                    if (w_ack_load) begin
                        if (r_load_cnt == w_load_lim) begin
                            r_load_cnt <= '0;
                            if (w_last_chan) begin
                                r_chan   <= '0;
                                r_weight <= '0;
                                if (r_state == STATE_LOAD) begin
                                    r_row <= r_row + ROW_W'(1);
                                end
                                r_state  <= STATE_SHIFT;
                                r_cmd    <= w_shift_cmd;
                                r_pend   <= ~out_ready;
                            end else begin
                                r_chan <= r_chan + CH_W'(1);
                                r_cmd  <= CMD_LOAD;
                            end
                        end else begin
                            r_load_cnt <= r_load_cnt + KL_W'(1);
                            r_cmd      <= CMD_LOAD;
                        end
                    end
                end
                STATE_SHIFT: begin
                    if (r_pend) begin
                        if (out_ready) begin
                            r_cmd  <= CMD_SHIFT;
                            r_pend <= 1'b0;
                        end
                    end else if (w_ack_shift) begin
                        if (w_last_weight) begin
                            r_weight <= '0;
                            if (w_last_chan) begin
                                r_chan <= '0;
                                if (w_last_row) begin
                                    r_state <= STATE_DRAIN;
                                end else begin
                                    r_state    <= STATE_LOAD;
                                    r_load_cnt <= '0;
                                    r_cmd      <= CMD_LOAD;
                                end
                            end else begin
                                r_chan <= r_chan + CH_W'(1);
                                r_cmd  <= w_shift_cmd;
                                r_pend <= ~out_ready;
                            end
                        end else begin
                            r_weight <= r_weight + W_W'(1);
                            r_cmd    <= w_shift_cmd;
                            r_pend   <= ~out_ready;
                        end
                    end
                end
                STATE_DRAIN: begin
                    if (w_pipe_empty) begin
                        r_state <= STATE_IDLE;
                        r_row   <= '0;
                    end
                end
                default: begin
                    r_state <= STATE_IDLE;
                end
            endcase
        end
    end

    conv_valid_pipe #(
        .DEPTH (VALID_LATENCY),
        .WIDTH (PAY_W)
    ) u_valid_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (~enable),
        .i_valid (w_cap),
        .i_data  (w_pay_in),
        .o_valid (w_pipe_valid),
        .o_data  (w_pay_out),
        .o_empty (w_pipe_empty)
    );

    assign input_interface_cmd  = r_cmd;
    assign input_interface_chan = r_chan;
    assign busy                 = (r_state != STATE_IDLE);
    assign valid                = w_pipe_valid;
    assign feature_idx          = w_pay_out[W_W-1:0];
    assign feature_row          = w_pay_out[W_W +: ROW_W];
    assign feature_chan         = w_pay_out[W_W+ROW_W +: CH_W];
    assign acc_last             = w_pay_out[PAY_W-3];
    assign acc_first            = w_pay_out[PAY_W-2];
    assign image_calc_fin       = w_pay_out[PAY_W-1];

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Scoreboard bench: two sequencers (result latency 3 and 1) share enable and
// out_ready, each with its own 2-cycle ack responder and expected-result queue.
module tb_conv_layer_sequencer;
    import conv_kernel_param::*;

    localparam int K = 3;
    localparam int C = 2;
    localparam int W = 4;

    typedef struct {
        int due; int row; int chan; int w; int first; int last; int fin;
    } sb_t;
    typedef struct { int cmd; int chan; } cmd_t;

    logic       clk = 1'b0;
    logic       rst_n, enable, cfg_stride, out_ready;
    logic [1:0] ack_d   [2];
    logic [1:0] cmd_w   [2];
    logic       ichan_w [2];
    logic       valid_w [2];
    logic [1:0] idx_w   [2];
    logic [2:0] row_w   [2];
    logic       chan_w  [2];
    logic       first_w [2];
    logic       last_w  [2];
    logic       fin_w   [2];
    logic       busy_w  [2];

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    cmd_t exp_cmd[$];
    sb_t  exp_tag[$];
    sb_t  sbq[2][$];
    int   cmd_ptr[2], shift_idx[2], valid_cnt[2], last_cnt[2], fin_cnt[2];
    int   fin_row[2], fin_idx[2], fin_chan[2];
    int   rsp_cnt[2];
    logic [1:0] rsp_type[2];
    logic [1:0] inj[2];
    logic spur[2];
    logic ready_prev = 1'b1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    conv_layer_sequencer #(.VALID_LATENCY(3)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .cfg_stride(cfg_stride),
        .input_interface_ack(ack_d[0]), .out_ready(out_ready),
        .input_interface_cmd(cmd_w[0]), .input_interface_chan(ichan_w[0]),
        .valid(valid_w[0]), .feature_idx(idx_w[0]), .feature_row(row_w[0]),
        .feature_chan(chan_w[0]), .acc_first(first_w[0]), .acc_last(last_w[0]),
        .image_calc_fin(fin_w[0]), .busy(busy_w[0]));

    conv_layer_sequencer #(.VALID_LATENCY(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .cfg_stride(cfg_stride),
        .input_interface_ack(ack_d[1]), .out_ready(out_ready),
        .input_interface_cmd(cmd_w[1]), .input_interface_chan(ichan_w[1]),
        .valid(valid_w[1]), .feature_idx(idx_w[1]), .feature_row(row_w[1]),
        .feature_chan(chan_w[1]), .acc_first(first_w[1]), .acc_last(last_w[1]),
        .image_calc_fin(fin_w[1]), .busy(busy_w[1]));

    task automatic chk(input string name, input int g, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s dut%0d: got %0d expected %0d (cycle %0d)", name, g, act, exp, cyc);
        end
    endtask

    // Expected command stream and result tags for one frame, loop order row/chan/weight
    task automatic build_frame(input int stride);
        int lr;
        sb_t e;
        lr = stride ? 2 : 5;
        exp_cmd.delete();
        exp_tag.delete();
        for (int c = 0; c < C; c++)
            for (int k = 0; k < K; k++) exp_cmd.push_back('{1, c});
        for (int r = 0; r <= lr; r++) begin
            for (int c = 0; c < C; c++) begin
                for (int w = 0; w < W; w++) begin
                    exp_cmd.push_back('{2, c});
                    e = '{0, r, c, w, (c == 0), (c == C-1), (c == C-1 && w == W-1 && r == lr)};
                    exp_tag.push_back(e);
                end
            end
            if (r != lr)
                for (int c = 0; c < C; c++)
                    for (int s = 0; s < (stride ? 2 : 1); s++) exp_cmd.push_back('{1, c});
        end
    endtask

    // Ack responder and result monitor, sampled on the falling edge
    initial begin
        for (int g = 0; g < 2; g++) begin
            ack_d[g] = ACK_IDLE; rsp_cnt[g] = 0; rsp_type[g] = ACK_IDLE;
        end
        forever begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                sb_t e;
                int lat;
                lat = (g == 0) ? 3 : 1;
                ack_d[g] = ACK_IDLE;
                if (!enable || !rst_n) begin
                    sbq[g].delete();
                    rsp_cnt[g] = 0;
                    if (inj[g] != ACK_IDLE) begin
                        ack_d[g] = inj[g];
                        inj[g] = ACK_IDLE;
                    end
                end else begin
                    if (rsp_cnt[g] == 1) begin
                        ack_d[g] = rsp_type[g];
                        rsp_cnt[g] = 0;
                        if (rsp_type[g] == ACK_SHIFT_FIN) begin
                            if (shift_idx[g] < exp_tag.size()) begin
                                e = exp_tag[shift_idx[g]];
                                e.due = cyc + lat;
                                sbq[g].push_back(e);
                            end else chk("shift_extra", g, 1, 0);
                            shift_idx[g]++;
                        end
                    end else if (rsp_cnt[g] == 2) begin
                        rsp_cnt[g] = 1;
                        if (spur[g] && rsp_type[g] == ACK_SHIFT_FIN) begin
                            ack_d[g] = ACK_LOAD_FIN;
                            spur[g] = 1'b0;
                        end
                    end
                    if (cmd_w[g] != CMD_IDLE) begin
                        chk("one_outstanding", g, rsp_cnt[g], 0);
                        if (cmd_ptr[g] < exp_cmd.size()) begin
                            chk("cmd_kind", g, cmd_w[g], exp_cmd[cmd_ptr[g]].cmd);
                            chk("cmd_chan", g, ichan_w[g], exp_cmd[cmd_ptr[g]].chan);
                        end else chk("cmd_extra", g, 1, 0);
                        cmd_ptr[g]++;
                        if (cmd_w[g] == CMD_SHIFT) chk("shift_during_stall", g, ready_prev, 1);
                        rsp_cnt[g] = 2;
                        rsp_type[g] = (cmd_w[g] == CMD_SHIFT) ? ACK_SHIFT_FIN : ACK_LOAD_FIN;
                    end
                    if (sbq[g].size() > 0 && sbq[g][0].due < cyc) begin
                        chk("valid_missing", g, cyc, sbq[g][0].due);
                        void'(sbq[g].pop_front());
                    end
                    if (valid_w[g]) begin
                        valid_cnt[g]++;
                        if (last_w[g]) last_cnt[g]++;
                        if (fin_w[g]) begin
                            fin_cnt[g]++;
                            fin_row[g] = row_w[g]; fin_idx[g] = idx_w[g]; fin_chan[g] = chan_w[g];
                        end
                        if (sbq[g].size() == 0) chk("valid_extra", g, 1, 0);
                        else begin
                            e = sbq[g].pop_front();
                            chk("latency", g, cyc, e.due);
                            chk("tag_idx", g, idx_w[g], e.w);
                            chk("tag_row", g, row_w[g], e.row);
                            chk("tag_chan", g, chan_w[g], e.chan);
                            chk("acc_first", g, first_w[g], e.first);
                            chk("acc_last", g, last_w[g], e.last);
                            chk("fin", g, fin_w[g], e.fin);
                        end
                    end else if (fin_w[g]) chk("fin_without_valid", g, 1, 0);
                end
            end
            ready_prev = out_ready;
        end
    end

    task automatic start_frame(input int stride);
        build_frame(stride);
        for (int g = 0; g < 2; g++) begin
            cmd_ptr[g] = 0; shift_idx[g] = 0; valid_cnt[g] = 0; last_cnt[g] = 0;
            fin_cnt[g] = 0; fin_row[g] = -1; fin_idx[g] = -1; fin_chan[g] = -1;
        end
        @(posedge clk); #1;
        cfg_stride = stride[0];
        enable = 1'b1;
    endtask

    task automatic finish_frame(input int nvalid, input int nlast, input int frow);
        int k;
        repeat (3) @(posedge clk);
        for (k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (!busy_w[0] && !busy_w[1]) break;
        end
        chk("frame_done_in_time", 0, int'(k < 3000), 1);
        repeat (4) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            chk("cmd_count", g, cmd_ptr[g], exp_cmd.size());
            chk("valid_count", g, valid_cnt[g], nvalid);
            chk("acc_last_count", g, last_cnt[g], nlast);
            chk("fin_count", g, fin_cnt[g], 1);
            chk("fin_row", g, fin_row[g], frow);
            chk("fin_idx", g, fin_idx[g], 3);
            chk("fin_chan", g, fin_chan[g], 1);
            chk("idle_no_restart", g, busy_w[g], 0);
        end
        @(posedge clk); #1 enable = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic wait_for(input int which, input int n);
        int k;
        for (k = 0; k < 3000; k++) begin
            @(negedge clk);
            if ((which == 0 ? cmd_ptr[0] : shift_idx[0]) >= n) break;
        end
        chk("wait_in_time", 0, int'(k < 3000), 1);
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; cfg_stride = 1'b0; out_ready = 1'b1;
        inj[0] = ACK_IDLE; inj[1] = ACK_IDLE; spur[0] = 1'b0; spur[1] = 1'b0;
        repeat (3) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            chk("reset_cmd", g, cmd_w[g], 0);
            chk("reset_valid", g, valid_w[g], 0);
            chk("reset_busy", g, busy_w[g], 0);
            chk("reset_fin", g, fin_w[g], 0);
            chk("reset_row", g, row_w[g], 0);
        end
        @(posedge clk); #1 rst_n = 1'b1;

        // stride 1 baseline
        start_frame(0);
        finish_frame(48, 24, 5);

        // stride 2; cfg_stride change mid-frame must be ignored
        start_frame(1);
        repeat (20) @(posedge clk);
        #1 cfg_stride = 1'b0;
        finish_frame(24, 12, 2);

        // out_ready stall mid-SHIFT
        start_frame(0);
        wait_for(1, 10);
        @(posedge clk); #1 out_ready = 1'b0;
        repeat (10) @(posedge clk);
        #1 out_ready = 1'b1;
        finish_frame(48, 24, 5);

        // spurious ACK_LOAD_FIN while a SHIFT is outstanding
        spur[0] = 1'b1; spur[1] = 1'b1;
        start_frame(0);
        finish_frame(48, 24, 5);
        chk("spurious_injected", 0, spur[0], 0);
        chk("spurious_injected", 1, spur[1], 0);

        // abort during the LOAD phase that feeds output row 2
        start_frame(0);
        wait_for(0, 25);
        @(posedge clk); #1 enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            chk("abort_busy", g, busy_w[g], 0);
            chk("abort_valid", g, valid_w[g], 0);
            chk("abort_cmd", g, cmd_w[g], 0);
        end
        @(posedge clk); #1 inj[0] = ACK_LOAD_FIN; inj[1] = ACK_SHIFT_FIN;
        @(posedge clk); #1 inj[0] = ACK_SHIFT_FIN; inj[1] = ACK_LOAD_FIN;
        repeat (3) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            chk("late_ack_busy", g, busy_w[g], 0);
            chk("late_ack_cmd", g, cmd_w[g], 0);
            chk("late_ack_valid", g, valid_w[g], 0);
        end
        start_frame(0);
        finish_frame(48, 24, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
